// File: rtl/store_buffer_if.sv
// Core/memory bus bundle for the store buffer.
// The slave modport is the buffer itself; master is whatever drives the core and memory side.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wd;
  logic [31:0]   cpu_rd;
  logic          stall;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rd;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wd;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wd, mem_rd, mem_ready,
    output cpu_rd, stall, mem_raddr, mem_we, mem_waddr, mem_wd, empty, count
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wd, mem_rd, mem_ready,
    input  cpu_rd, stall, mem_raddr, mem_we, mem_waddr, mem_wd, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory, with
// youngest-match load forwarding from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] word_q [DEPTH];
  logic [WW-1:0] word_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];

  logic          full;
  logic          drain;
  logic          accept;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  // A full buffer still takes a store when the head leaves in the same cycle.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    drain   = bus.mem_ready & (count_q != '0);
    accept  = bus.cpu_we & (~full | drain);
    head_d  = drain  ? head_q + PW'(1) : head_q;
    tail_d  = accept ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (accept && !drain) begin
      count_d = count_q + CW'(1);
    end else if (!accept && drain) begin
      count_d = count_q - CW'(1);
    end
    word_d = word_q;
    data_d = data_q;
    if (accept) begin
      word_d[tail_q] = bus.cpu_addr[AW-1:2];
      data_d[tail_q] = bus.cpu_wd;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest store to that word.
  always_comb begin
    fwd_data = bus.mem_rd;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (word_q[idx] == bus.cpu_addr[AW-1:2])) begin
        fwd_data = data_q[idx];
      end
    end
  end

  assign bus.cpu_rd    = fwd_data;
  assign bus.stall     = bus.cpu_we & full & ~bus.mem_ready;
  assign bus.mem_raddr = bus.cpu_addr;
  assign bus.mem_we    = drain;
  assign bus.mem_waddr = {word_q[head_q], 2'b00};
  assign bus.mem_wd    = data_q[head_q];
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all checked
// against a queue-based model of the posted-write buffer.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-3:0] word;
    logic [31:0]   data;
  } entry_t;

  entry_t modelQ[$];
  int testCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One bus cycle: drive at the falling edge, check the combinational view, then advance the model.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                               input logic ready, input logic [31:0] rdata);
    int          n;
    logic        expMemWe;
    logic        expFull;
    logic        expStall;
    logic        expAccept;
    logic [31:0] expRd;
    @(negedge clk);
    sb_if.cpu_we    = we;
    sb_if.cpu_addr  = addr;
    sb_if.cpu_wd    = wd;
    sb_if.mem_ready = ready;
    sb_if.mem_rd    = rdata;
    #1;
    n         = modelQ.size();
    expMemWe  = ready && (n != 0);
    expFull   = (n == DEPTH);
    expStall  = we && expFull && !ready;
    expAccept = we && (!expFull || expMemWe);
    expRd     = rdata;
    for (int i = 0; i < n; i++) begin
      if (modelQ[i].word == addr[AW-1:2]) expRd = modelQ[i].data;
    end
    checkOutput("count",     32'(sb_if.count), 32'(n));
    checkOutput("empty",     32'(sb_if.empty), 32'(n == 0));
    checkOutput("mem_we",    32'(sb_if.mem_we), 32'(expMemWe));
    checkOutput("stall",     32'(sb_if.stall), 32'(expStall));
    checkOutput("cpu_rd",    sb_if.cpu_rd, expRd);
    checkOutput("mem_raddr", sb_if.mem_raddr, addr);
    if (expMemWe) begin
      checkOutput("mem_waddr", sb_if.mem_waddr, {modelQ[0].word, 2'b00});
      checkOutput("mem_wd",    sb_if.mem_wd, modelQ[0].data);
      void'(modelQ.pop_front());
    end
    if (expAccept) begin
      entry_t e;
      e.word = addr[AW-1:2];
      e.data = wd;
      modelQ.push_back(e);
    end
  endtask

  task automatic resetCycles(input int n);
    @(negedge clk);
    reset           = 1'b0;
    sb_if.cpu_we    = 1'b1;
    sb_if.mem_ready = 1'b1;
    modelQ.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_empty",  32'(sb_if.empty), 32'd1);
      checkOutput("rst_mem_we", 32'(sb_if.mem_we), 32'd0);
      checkOutput("rst_stall",  32'(sb_if.stall), 32'd0);
      checkOutput("rst_count",  32'(sb_if.count), 32'd0);
    end
    reset        = 1'b1;
    sb_if.cpu_we = 1'b0;
  endtask

  initial begin
    sb_if.cpu_we    = 1'b0;
    sb_if.cpu_addr  = '0;
    sb_if.cpu_wd    = '0;
    sb_if.mem_ready = 1'b0;
    sb_if.mem_rd    = '0;

    // Basic drain
    resetCycles(2);
    applyStimulus(1'b1, 32'd88, 32'h0000000C, 1'b1, 32'h0);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);
    checkOutput("basic_waddr", sb_if.mem_waddr, 32'd88);
    checkOutput("basic_wd",    sb_if.mem_wd, 32'h0000000C);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);
    checkOutput("basic_empty", 32'(sb_if.empty), 32'd1);

    // Fill and stall, then accept at full while the head drains
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(80 + 4 * i), 32'(i + 1), 1'b0, 32'h0);
    applyStimulus(1'b1, 32'd96, 32'd5, 1'b0, 32'h0);
    checkOutput("fill_stall", 32'(sb_if.stall), 32'd1);
    checkOutput("fill_count", 32'(sb_if.count), 32'd4);
    applyStimulus(1'b1, 32'd96, 32'd5, 1'b1, 32'h0);
    checkOutput("full_drain_waddr", sb_if.mem_waddr, 32'd80);
    checkOutput("full_drain_stall", 32'(sb_if.stall), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b0, 32'h0);
    checkOutput("full_count_kept", 32'(sb_if.count), 32'd4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);

    // Forwarding picks the youngest matching store
    applyStimulus(1'b1, 32'd84, 32'hAA, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'd84, 32'hBB, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'd84, 32'h0, 1'b0, 32'h11);
    checkOutput("fwd_youngest", sb_if.cpu_rd, 32'hBB);
    applyStimulus(1'b0, 32'd80, 32'h0, 1'b0, 32'h11);
    checkOutput("fwd_miss", sb_if.cpu_rd, 32'h11);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd84, 32'h0, 1'b1, 32'h22);

    // Ten stores with toggling ready exercise pointer wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(200 + 4 * i), 32'(32'h100 + i), 1'(i % 2), 32'h0);
      checkOutput("count_le_depth", 32'(sb_if.count <= DEPTH), 32'd1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);

    // Reset mid-operation discards buffered stores
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(300 + 4 * i), 32'(32'hC0 + i), 1'b0, 32'h0);
    resetCycles(1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);

    // Enqueue and drain together at count==1
    applyStimulus(1'b1, 32'd60, 32'h3C, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'd100, 32'h64, 1'b1, 32'h0);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);
    checkOutput("c1_waddr", sb_if.mem_waddr, 32'd100);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 32'h0);

    // Random traffic on a small address pool so forwarding hits are frequent
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetCycles(1);
      end else begin
        applyStimulus(1'($urandom_range(0, 1)),
                      {24'h0, 3'($urandom_range(0, 7)), 5'h0} | 32'($urandom_range(0, 3)),
                      32'($urandom), 1'($urandom_range(0, 2) != 0), 32'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
